audrey_i2s_tx: RTL and testbench

AUDREY_I2S_TX -- requirements
Module: audrey_i2s_tx

---
 rtl/audrey_pkg.sv | 19 +
 rtl/audrey_i2s_tx.sv | 106 ++++++++++
 tb/tb_audrey_i2s_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/audrey_pkg.sv
// Shared constants for the Audrey audio output path.
// Frame geometry: 1024 clk per 48 kHz frame, 64 bit slots of 16 clk each,
// 16-bit signed PCM samples per channel.
package audrey_pkg;

  localparam int unsigned CLKS_PER_FRAME  = 1024;
  localparam int unsigned CLKS_PER_BCLK   = 16;
  localparam int unsigned SLOTS_PER_FRAME = 64;
  localparam int unsigned SAMPLE_W        = 16;

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_FRAME);
  localparam int unsigned SLOT_W    = $clog2(SLOTS_PER_FRAME);
  localparam int unsigned BCLK_BIT  = $clog2(CLKS_PER_BCLK) - 1;
  localparam int unsigned BIT_IDX_W = $clog2(SAMPLE_W);

  // Frame-counter value at which the sample inputs are captured.
  localparam logic [CNT_W-1:0] LATCH_CNT_DEFAULT = 10'd1000;

endpackage

// File: rtl/audrey_i2s_tx.sv
// Philips I2S transmitter for the Audrey mixed voice output.
//
// A free-running 10-bit frame counter (one 48 kHz frame per 1024 clk) drives
// everything. Samples are captured into shadow registers at LATCH_CNT, copied
// into hold registers at the start of the next frame, and shifted out MSB
// first one bit per 16-clk slot, so the MSB follows the lrck edge by one bclk.
//
// Ports:
//   clk           49.152 MHz audio clock
//   rst_n         asynchronous active-low reset (deassertion synchronised)
//   enable        run control; low holds the block idle, counter at 0
//   sample_l/r    16-bit signed PCM samples
//   sample_strobe one-clk pulse at the start of each frame
//   i2s_bclk      bit clock, clk/16
//   i2s_lrck      word select, 0 = left, 1 = right
//   i2s_sdata     serial data
module audrey_i2s_tx
  import audrey_pkg::*;
#(
  parameter logic [CNT_W-1:0] LATCH_CNT = LATCH_CNT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  output logic                sample_strobe,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata
);

  logic [1:0]           rst_sync_q;
  logic                 run;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SLOT_W-1:0]    slot;
  logic [SAMPLE_W-1:0]  shadow_l_q, shadow_r_q;
  logic [SAMPLE_W-1:0]  hold_l_q, hold_r_q;
  logic [BIT_IDX_W-1:0] bit_idx_l, bit_idx_r;
  logic                 data_bit;
  logic                 bclk_d, lrck_d, sdata_d;
  logic                 bclk_q, lrck_q, sdata_q;

  // Reset asserts immediately but releases on a clean edge; run stays low
  // until the synchroniser has filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run           = enable & rst_sync_q[1];
  assign slot          = cnt_q[CNT_W-1 -: SLOT_W];
  assign sample_strobe = run & (cnt_q == '0);
  assign cnt_d         = run ? cnt_q + 1'b1 : '0;

  // Slot 1 carries bit 15 of the left word, slot 33 bit 15 of the right word.
  assign bit_idx_l = BIT_IDX_W'(SLOT_W'(SAMPLE_W) - slot);
  assign bit_idx_r = BIT_IDX_W'(SLOT_W'(3 * SAMPLE_W) - slot);

  always_comb begin
    data_bit = 1'b0;
    if (slot >= SLOT_W'(1) && slot <= SLOT_W'(SAMPLE_W)) begin
      data_bit = hold_l_q[bit_idx_l];
    end else if (slot >= SLOT_W'(2 * SAMPLE_W + 1) && slot <= SLOT_W'(3 * SAMPLE_W)) begin
      data_bit = hold_r_q[bit_idx_r];
    end
    // Gating with run forces the outputs low on the first edge after enable drops.
    bclk_d  = run & cnt_q[BCLK_BIT];
    lrck_d  = run & slot[SLOT_W-1];
    sdata_d = run & data_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (run && (cnt_q == LATCH_CNT)) begin
        shadow_l_q <= sample_l;
        shadow_r_q <= sample_r;
      end
      if (sample_strobe) begin
        hold_l_q <= shadow_l_q;
        hold_r_q <= shadow_r_q;
      end
      bclk_q  <= bclk_d;
      lrck_q  <= lrck_d;
      sdata_q <= sdata_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;

endmodule

// File: tb/tb_audrey_i2s_tx.sv
// Self-checking bench for audrey_i2s_tx.
// The reference model works at frame level: the word sent in a frame is the
// sample pair seen at the latch count of the previous running frame, and each
// clk's expected bclk/lrck/sdata is computed from the slot arithmetic.
module tb_audrey_i2s_tx;

  localparam int LATCH = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_strobe;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;

  always #5 clk = ~clk;

  audrey_i2s_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_strobe(sample_strobe),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata)
  );

  int checks  = 0;
  int passed  = 0;
  int cyc_err = 0;

  bit          m_en = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_sh_l = '0, m_sh_r = '0;
  logic [15:0] m_tx_l = '0, m_tx_r = '0;
  logic [15:0] rx_l = '0, rx_r = '0;
  logic [15:0] ret_l, ret_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic flush(input string tag);
    check(tag, cyc_err, 0);
    cyc_err = 0;
  endtask

  task automatic set_en(input bit b);
    enable = b;
    m_en   = b;
    if (b) m_cnt = 0;
  endtask

  task automatic model_reset();
    m_en   = 1'b0;
    m_sh_l = '0;
    m_sh_r = '0;
    m_tx_l = '0;
    m_tx_r = '0;
    rx_l   = '0;
    rx_r   = '0;
  endtask

  // One clk: check strobe and apply latch/hold rules before the edge, then
  // check the registered serial outputs after it.
  task automatic tick();
    int   c;
    int   s;
    logic exp_sd;
    #1;
    c = m_cnt % 1024;
    if (m_en) begin
      if (sample_strobe !== (c == 0)) cyc_err++;
      if (c == LATCH) begin
        m_sh_l = sample_l;
        m_sh_r = sample_r;
      end
      if (c == 0) begin
        m_tx_l = m_sh_l;
        m_tx_r = m_sh_r;
        rx_l   = '0;
        rx_r   = '0;
      end
    end else if (sample_strobe !== 1'b0) begin
      cyc_err++;
    end
    @(posedge clk);
    #1;
    if (m_en) begin
      s      = c / 16;
      exp_sd = 1'b0;
      if (s >= 1 && s <= 16) begin
        exp_sd = m_tx_l[16 - s];
        rx_l[16 - s] = i2s_sdata;
      end else if (s >= 33 && s <= 48) begin
        exp_sd = m_tx_r[48 - s];
        rx_r[48 - s] = i2s_sdata;
      end
      if (i2s_bclk !== c[3]) cyc_err++;
      if (i2s_lrck !== c[9]) cyc_err++;
      if (i2s_sdata !== exp_sd) cyc_err++;
      if (c == 783) begin
        check("word_l", {16'h0, rx_l}, {16'h0, m_tx_l});
        check("word_r", {16'h0, rx_r}, {16'h0, m_tx_r});
      end
      if (c == 1023) flush("frame_timing");
      m_cnt++;
    end else if ({i2s_bclk, i2s_lrck, i2s_sdata} !== 3'b000) begin
      cyc_err++;
    end
  endtask

  task automatic run_until(input int target);
    while (m_cnt < target) tick();
  endtask

  initial begin
    // Asynchronous reset, before any clk edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {28'h0, sample_strobe, i2s_bclk, i2s_lrck, i2s_sdata}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    flush("post_reset_idle");

    // Fixed data: frame 0 sends zeros, frame 1 sends 8001 / 7FFE.
    sample_l = 16'h8001;
    sample_r = 16'h7FFE;
    set_en(1'b1);
    #1;
    check("strobe_on_enable", {31'h0, sample_strobe}, 32'h1);
    run_until(2048);
    check("fixed_l", {16'h0, rx_l}, 32'h8001);
    check("fixed_r", {16'h0, rx_r}, 32'h7FFE);

    // Latch window: change one clk after the latch count.
    sample_l = 16'h1234;
    run_until(2048 + LATCH + 1);
    sample_l = 16'hABCD;
    run_until(3072 + 784);
    check("latch_old", {16'h0, rx_l}, 32'h1234);
    run_until(4096 + 784);
    check("latch_new", {16'h0, rx_l}, 32'hABCD);

    // Samples changing every clk; only the latch-cycle value may reach the line.
    while (m_cnt < 4880 + 2048) begin
      sample_l = 16'($urandom);
      sample_r = 16'($urandom);
      tick();
    end

    // Enable drop at cnt 300, idle for 2000 clk, then restart.
    run_until(7168 + 300);
    ret_l = m_sh_l;
    ret_r = m_sh_r;
    set_en(1'b0);
    tick();
    check("drop_outputs", {28'h0, sample_strobe, i2s_bclk, i2s_lrck, i2s_sdata}, 32'h0);
    repeat (2000) begin
      sample_l = 16'($urandom);
      sample_r = 16'($urandom);
      tick();
    end
    flush("disabled_idle");
    set_en(1'b1);
    #1;
    check("strobe_on_reenable", {31'h0, sample_strobe}, 32'h1);
    run_until(784);
    check("retained_l", {16'h0, rx_l}, {16'h0, ret_l});
    check("retained_r", {16'h0, rx_r}, {16'h0, ret_r});

    // Reset in the middle of slot 20 while bclk is high.
    sample_l = 16'h5A5A;
    sample_r = 16'hA5A5;
    run_until(1024 + 330);
    check("pre_reset_bclk", {31'h0, i2s_bclk}, 32'h1);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    model_reset();
    #1;
    check("async_reset_outputs",
          {28'h0, sample_strobe, i2s_bclk, i2s_lrck, i2s_sdata}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    flush("reset_idle");
    set_en(1'b1);
    run_until(784);
    check("reset_frame_l", {16'h0, rx_l}, 32'h0);
    check("reset_frame_r", {16'h0, rx_r}, 32'h0);
    run_until(2048 + 784);
    check("after_reset_l", {16'h0, rx_l}, 32'h5A5A);
    check("after_reset_r", {16'h0, rx_r}, 32'hA5A5);
    flush("final_timing");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
